// File: rtl/apb_global_pkg.sv
// Shared types and constants for the APB requester family.
package apb_global_pkg;

  typedef enum logic [1:0] {
    IDLE_STATE   = 2'd0,
    SETUP_STATE  = 2'd1,
    ACCESS_STATE = 2'd2
  } operation_states_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 256;
  localparam int RSP_DATA_MAX           = 32;

  typedef struct packed {
    logic [RSP_DATA_MAX-1:0] rdata;
    logic                    slverr;
    logic                    timeout;
  } apb_bridge_rsp_s;

  // Index width that stays legal for a single completer.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Maps a byte address onto a completer window: range flag, index and one-hot select.
module apb_addr_decoder
  import apb_global_pkg::*;
#(
  parameter int          NO_OF_SLAVES   = 16,
  parameter int          ADDRESS_LENGTH = 32,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter logic [31:0] SLAVE_SPAN     = 32'h1000,
  parameter int          IDX_W          = idx_width(NO_OF_SLAVES)
) (
  input  logic [ADDRESS_LENGTH-1:0] addr_i,
  output logic                      in_range_o,
  output logic [IDX_W-1:0]          idx_o,
  output logic [NO_OF_SLAVES-1:0]   psel_o
);

  localparam int SPAN_SHIFT = $clog2(SLAVE_SPAN);

  logic [31:0] addr_ext;
  logic [31:0] window;

  // Window number is the offset from the base divided by the power-of-two span.
  always_comb begin
    addr_ext                       = 32'd0;
    addr_ext[ADDRESS_LENGTH-1:0]   = addr_i;
    window     = (addr_ext - BASE_ADDR) >> SPAN_SHIFT;
    in_range_o = (addr_ext >= BASE_ADDR) && (window < 32'(NO_OF_SLAVES));
    idx_o      = window[IDX_W-1:0];
    psel_o     = '0;
    for (int i = 0; i < NO_OF_SLAVES; i++) begin
      psel_o[i] = in_range_o && (window == 32'(i));
    end
  end

endmodule

// File: rtl/apb_multi_slave_master.sv
// APB4 requester: valid/ready command port to NO_OF_SLAVES completers with a one-entry response buffer.
module apb_multi_slave_master
  import apb_global_pkg::*;
#(
  parameter int          NO_OF_SLAVES   = 16,
  parameter int          ADDRESS_LENGTH = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter logic [31:0] SLAVE_SPAN     = 32'h1000,
  parameter int          TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                               pclk,
  input  logic                               preset_n,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic                               req_write,
  input  logic [ADDRESS_LENGTH-1:0]          req_addr,
  input  logic [DATA_WIDTH-1:0]              req_wdata,
  input  logic [DATA_WIDTH/8-1:0]            req_strb,
  input  logic [2:0]                         req_prot,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [DATA_WIDTH-1:0]              rsp_rdata,
  output logic                               rsp_slverr,
  output logic                               rsp_timeout,
  output logic [ADDRESS_LENGTH-1:0]          paddr,
  output logic [NO_OF_SLAVES-1:0]            psel,
  output logic                               penable,
  output logic                               pwrite,
  output logic [2:0]                         pprot,
  output logic [DATA_WIDTH/8-1:0]            pstrb,
  output logic [DATA_WIDTH-1:0]              pwdata,
  input  logic [NO_OF_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NO_OF_SLAVES-1:0]            pready,
  input  logic [NO_OF_SLAVES-1:0]            pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = idx_width(NO_OF_SLAVES);
  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  operation_states_e         state_q,   state_d;
  logic [ADDRESS_LENGTH-1:0] paddr_q,   paddr_d;
  logic [NO_OF_SLAVES-1:0]   psel_q,    psel_d;
  logic                      penable_q, penable_d;
  logic                      pwrite_q,  pwrite_d;
  logic [2:0]                pprot_q,   pprot_d;
  logic [STRB_W-1:0]         pstrb_q,   pstrb_d;
  logic [DATA_WIDTH-1:0]     pwdata_q,  pwdata_d;
  logic [IDX_W-1:0]          idx_q,     idx_d;
  logic [CNT_W-1:0]          cnt_q,     cnt_d;
  logic                      rsp_valid_q, rsp_valid_d;
  apb_bridge_rsp_s           rsp_q,     rsp_d;
  logic                      derr_pend_q, derr_pend_d;

  logic                    dec_in_range;
  logic [IDX_W-1:0]        dec_idx;
  logic [NO_OF_SLAVES-1:0] dec_psel;
  logic                    sel_ready, sel_err, rsp_space, timeout_hit, done;
  logic                    accept, start, derr;
  logic [DATA_WIDTH-1:0]   sel_rdata;

  apb_addr_decoder #(
    .NO_OF_SLAVES  (NO_OF_SLAVES),
    .ADDRESS_LENGTH(ADDRESS_LENGTH),
    .BASE_ADDR     (BASE_ADDR),
    .SLAVE_SPAN    (SLAVE_SPAN),
    .IDX_W         (IDX_W)
  ) u_decoder (
    .addr_i    (req_addr),
    .in_range_o(dec_in_range),
    .idx_o     (dec_idx),
    .psel_o    (dec_psel)
  );

  // Completion waits for buffer space, so a back-to-back response can never overwrite a held one.
  always_comb begin
    sel_ready   = pready[idx_q];
    sel_err     = pslverr[idx_q];
    sel_rdata   = prdata[int'(idx_q) * DATA_WIDTH +: DATA_WIDTH];
    rsp_space   = !rsp_valid_q || rsp_ready;
    timeout_hit = (TIMEOUT_CYCLES > 0) && !sel_ready && (cnt_q == CNT_LAST);
    done        = (state_q == ACCESS_STATE) && rsp_space && (sel_ready || timeout_hit);
    req_ready   = preset_n && !derr_pend_q && rsp_space && ((state_q == IDLE_STATE) || done);
    accept      = req_valid && req_ready;
    start       = accept && dec_in_range;
    derr        = accept && !dec_in_range;
  end

  // Next-state for the FSM, APB phase registers, timeout counter and response buffer.
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pprot_d     = pprot_q;
    pstrb_d     = pstrb_q;
    pwdata_d    = pwdata_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q && !rsp_ready;
    rsp_d       = rsp_q;
    derr_pend_d = derr_pend_q;

    case (state_q)
      IDLE_STATE:   state_d = start ? SETUP_STATE : IDLE_STATE;
      SETUP_STATE:  state_d = ACCESS_STATE;
      ACCESS_STATE: begin
        if (done) state_d = start ? SETUP_STATE : IDLE_STATE;
        else      state_d = ACCESS_STATE;
      end
      default:      state_d = IDLE_STATE;
    endcase

    if (start) begin
      paddr_d   = req_addr;
      psel_d    = dec_psel;
      penable_d = 1'b0;
      pwrite_d  = req_write;
      pprot_d   = req_prot;
      pstrb_d   = req_write ? req_strb : '0;
      pwdata_d  = req_wdata;
      idx_d     = dec_idx;
    end else if (state_q == SETUP_STATE) begin
      penable_d = 1'b1;
    end else if (done) begin
      psel_d    = '0;
      penable_d = 1'b0;
    end else begin
      penable_d = penable_q;
    end

    if (state_q == SETUP_STATE) begin
      cnt_d = '0;
    end else if ((state_q == ACCESS_STATE) && !sel_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    // A decode error accepted alongside a completion is parked until the buffer frees.
    if (done) begin
      rsp_valid_d   = 1'b1;
      rsp_d.rdata   = '0;
      rsp_d.timeout = !sel_ready;
      rsp_d.slverr  = sel_err || !sel_ready;
      if (sel_ready && !pwrite_q) rsp_d.rdata[DATA_WIDTH-1:0] = sel_rdata;
      else                        rsp_d.rdata = '0;
      derr_pend_d   = derr;
    end else if (derr || (derr_pend_q && rsp_space)) begin
      rsp_valid_d   = 1'b1;
      rsp_d.rdata   = '0;
      rsp_d.slverr  = 1'b1;
      rsp_d.timeout = 1'b0;
      derr_pend_d   = 1'b0;
    end else begin
      derr_pend_d   = derr_pend_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q     <= IDLE_STATE;
      paddr_q     <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pprot_q     <= 3'd0;
      pstrb_q     <= '0;
      pwdata_q    <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      derr_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pprot_q     <= pprot_d;
      pstrb_q     <= pstrb_d;
      pwdata_q    <= pwdata_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
      derr_pend_q <= derr_pend_d;
    end
  end

  assign paddr       = paddr_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign pprot       = pprot_q;
  assign pstrb       = pstrb_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_q.rdata[DATA_WIDTH-1:0];
  assign rsp_slverr  = rsp_q.slverr;
  assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_multi_slave_master.sv
// Directed self-checking bench for apb_multi_slave_master (16 completers, timeout of 4).
module tb_apb_multi_slave_master;

  logic         pclk, preset_n;
  logic         req_valid, req_ready, req_write;
  logic [31:0]  req_addr, req_wdata;
  logic [3:0]   req_strb;
  logic [2:0]   req_prot;
  logic         rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
  logic [31:0]  rsp_rdata, paddr, pwdata;
  logic [15:0]  psel, pready, pslverr;
  logic         penable, pwrite;
  logic [2:0]   pprot;
  logic [3:0]   pstrb;
  logic [511:0] prdata;

  int checks = 0;
  int passes = 0;

  apb_multi_slave_master #(
    .NO_OF_SLAVES(16), .ADDRESS_LENGTH(32), .DATA_WIDTH(32),
    .BASE_ADDR(32'h0), .SLAVE_SPAN(32'h1000), .TIMEOUT_CYCLES(4)
  ) dut (
    .pclk(pclk), .preset_n(preset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pprot(pprot),
    .pstrb(pstrb), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic drive_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    req_strb = 4'hF; req_prot = 3'b010;
  endtask

  task automatic test_reset();
    preset_n = 1'b0;
    tick(); tick();
    checks++; if (psel !== 16'h0) $display("FAIL rst_psel: got %h expected %h", psel, 16'h0); else passes++;
    checks++; if (penable !== 1'b0) $display("FAIL rst_penable: got %b expected 0", penable); else passes++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); else passes++;
    checks++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready: got %b expected 0", req_ready); else passes++;
    checks++; if (paddr !== 32'h0) $display("FAIL rst_paddr: got %h expected 0", paddr); else passes++;
    preset_n = 1'b1;
    tick();
    checks++; if (req_ready !== 1'b1) $display("FAIL rst_ready_after: got %b expected 1", req_ready); else passes++;
  endtask

  task automatic test_write();
    pslverr[7] = 1'b1;
    drive_cmd(1'b1, 32'h2004, 32'hA5A5_0001);
    #1;
    checks++; if (req_ready !== 1'b1) $display("FAIL t1_req_ready: got %b expected 1", req_ready); else passes++;
    tick();
    req_valid = 1'b0;
    checks++; if (psel !== 16'h0004) $display("FAIL t1_psel_setup: got %h expected 0004", psel); else passes++;
    checks++; if (penable !== 1'b0) $display("FAIL t1_penable_setup: got %b expected 0", penable); else passes++;
    checks++; if (paddr !== 32'h2004) $display("FAIL t1_paddr: got %h expected 00002004", paddr); else passes++;
    checks++; if (pwdata !== 32'hA5A5_0001) $display("FAIL t1_pwdata: got %h expected a5a50001", pwdata); else passes++;
    checks++; if (pstrb !== 4'hF || pwrite !== 1'b1 || pprot !== 3'b010)
      $display("FAIL t1_ctrl: got strb %h wr %b prot %h expected f 1 2", pstrb, pwrite, pprot); else passes++;
    tick();
    checks++; if (psel !== 16'h0004 || penable !== 1'b1) $display("FAIL t1_access: got psel %h en %b expected 0004 1", psel, penable); else passes++;
    tick();
    checks++; if (rsp_valid !== 1'b1) $display("FAIL t1_rsp_valid: got %b expected 1", rsp_valid); else passes++;
    checks++; if (rsp_slverr !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0)
      $display("FAIL t1_rsp: got err %b to %b rdata %h expected 0 0 0", rsp_slverr, rsp_timeout, rsp_rdata); else passes++;
    checks++; if (psel !== 16'h0 || penable !== 1'b0) $display("FAIL t1_idle: got psel %h en %b expected 0 0", psel, penable); else passes++;
    tick();
    checks++; if (rsp_valid !== 1'b0) $display("FAIL t1_drain: got %b expected 0", rsp_valid); else passes++;
    pslverr[7] = 1'b0;
  endtask

  task automatic test_read_wait();
    pready[5] = 1'b0;
    prdata[5*32 +: 32] = 32'hDEAD_BEEF;
    drive_cmd(1'b0, 32'h5010, 32'h1111_2222);
    tick();
    req_valid = 1'b0;
    checks++; if (psel !== 16'h0020 || pstrb !== 4'h0 || pwrite !== 1'b0)
      $display("FAIL t2_setup: got psel %h strb %h wr %b expected 0020 0 0", psel, pstrb, pwrite); else passes++;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++; if (penable !== 1'b1 || rsp_valid !== 1'b0)
        $display("FAIL t2_wait_c%0d: got en %b rv %b expected 1 0", c, penable, rsp_valid); else passes++;
      if (c == 4) pready[5] = 1'b1;
    end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || rsp_slverr !== 1'b0)
      $display("FAIL t2_rsp: got rv %b rdata %h err %b expected 1 deadbeef 0", rsp_valid, rsp_rdata, rsp_slverr); else passes++;
    tick();
  endtask

  task automatic test_back_to_back();
    prdata[1*32 +: 32] = 32'h1234_5678;
    drive_cmd(1'b1, 32'h0008, 32'h0000_00AA);
    tick();
    drive_cmd(1'b0, 32'h100C, 32'h0);
    #1;
    checks++; if (psel !== 16'h0001 || req_ready !== 1'b0)
      $display("FAIL t3_setup_a: got psel %h rdy %b expected 0001 0", psel, req_ready); else passes++;
    tick();
    checks++; if (psel !== 16'h0001 || penable !== 1'b1 || req_ready !== 1'b1)
      $display("FAIL t3_access_a: got psel %h en %b rdy %b expected 0001 1 1", psel, penable, req_ready); else passes++;
    tick();
    req_valid = 1'b0;
    checks++; if (psel !== 16'h0002 || penable !== 1'b0)
      $display("FAIL t3_setup_b: got psel %h en %b expected 0002 0", psel, penable); else passes++;
    checks++; if (rsp_valid !== 1'b1 || rsp_slverr !== 1'b0)
      $display("FAIL t3_rsp_a: got rv %b err %b expected 1 0", rsp_valid, rsp_slverr); else passes++;
    tick();
    checks++; if (psel !== 16'h0002 || penable !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL t3_access_b: got psel %h en %b rv %b expected 0002 1 0", psel, penable, rsp_valid); else passes++;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 || psel !== 16'h0)
      $display("FAIL t3_rsp_b: got rv %b rdata %h psel %h expected 1 12345678 0", rsp_valid, rsp_rdata, psel); else passes++;
    tick();
  endtask

  task automatic test_out_of_range();
    drive_cmd(1'b0, 32'h0001_0000, 32'h0);
    #1;
    checks++; if (req_ready !== 1'b1) $display("FAIL t4_req_ready: got %b expected 1", req_ready); else passes++;
    tick();
    req_valid = 1'b0;
    checks++; if (psel !== 16'h0 || penable !== 1'b0) $display("FAIL t4_no_apb: got psel %h en %b expected 0 0", psel, penable); else passes++;
    checks++; if (rsp_valid !== 1'b1 || rsp_slverr !== 1'b1 || rsp_rdata !== 32'h0 || rsp_timeout !== 1'b0)
      $display("FAIL t4_rsp: got rv %b err %b rdata %h to %b expected 1 1 0 0", rsp_valid, rsp_slverr, rsp_rdata, rsp_timeout); else passes++;
    tick();
    checks++; if (psel !== 16'h0 || rsp_valid !== 1'b0) $display("FAIL t4_after: got psel %h rv %b expected 0 0", psel, rsp_valid); else passes++;
  endtask

  task automatic test_timeout();
    prdata[3*32 +: 32] = 32'hCAFE_0003;
    for (int rep = 0; rep < 2; rep++) begin
      pready[3] = 1'b0;
      drive_cmd(1'b0, 32'h3000, 32'h0);
      tick();
      req_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
        tick();
        checks++; if (psel !== 16'h0008 || penable !== 1'b1)
          $display("FAIL t5_access_r%0d_c%0d: got psel %h en %b expected 0008 1", rep, c, psel, penable); else passes++;
        if (rep == 1 && c == 4) pready[3] = 1'b1;
      end
      tick();
      if (rep == 0) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_slverr !== 1'b1 || rsp_timeout !== 1'b1 || rsp_rdata !== 32'h0)
          $display("FAIL t5_timeout: got rv %b err %b to %b rdata %h expected 1 1 1 0", rsp_valid, rsp_slverr, rsp_timeout, rsp_rdata); else passes++;
      end else begin
        checks++; if (rsp_valid !== 1'b1 || rsp_slverr !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'hCAFE_0003)
          $display("FAIL t5_late_ready: got rv %b err %b to %b rdata %h expected 1 0 0 cafe0003", rsp_valid, rsp_slverr, rsp_timeout, rsp_rdata); else passes++;
      end
      checks++; if (psel !== 16'h0 || penable !== 1'b0)
        $display("FAIL t5_release_r%0d: got psel %h en %b expected 0 0", rep, psel, penable); else passes++;
      tick();
    end
    pready[3] = 1'b1;
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    prdata[4*32 +: 32] = 32'h0BAD_F00D;
    drive_cmd(1'b0, 32'h4000, 32'h0);
    tick();
    req_valid = 1'b0;
    tick(); tick();
    drive_cmd(1'b0, 32'h4004, 32'h0);
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'h0BAD_F00D)
        $display("FAIL t6_hold_c%0d: got rdy %b rv %b rdata %h expected 0 1 0badf00d", c, req_ready, rsp_valid, rsp_rdata); else passes++;
      tick();
    end
    checks++; if (psel !== 16'h0) $display("FAIL t6_no_accept: got psel %h expected 0", psel); else passes++;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) $display("FAIL t6_release: got %b expected 1", req_ready); else passes++;
    tick();
    req_valid = 1'b0;
    checks++; if (psel !== 16'h0010 || rsp_valid !== 1'b0)
      $display("FAIL t6_drain_accept: got psel %h rv %b expected 0010 0", psel, rsp_valid); else passes++;
    tick(); tick();
    checks++; if (rsp_valid !== 1'b1) $display("FAIL t6_second_rsp: got %b expected 1", rsp_valid); else passes++;
    tick();
  endtask

  task automatic test_reset_access();
    pready[6] = 1'b0;
    drive_cmd(1'b0, 32'h6000, 32'h0);
    tick();
    req_valid = 1'b0;
    tick();
    checks++; if (psel !== 16'h0040 || penable !== 1'b1)
      $display("FAIL t7_access: got psel %h en %b expected 0040 1", psel, penable); else passes++;
    preset_n = 1'b0;
    tick();
    checks++; if (psel !== 16'h0 || penable !== 1'b0 || rsp_valid !== 1'b0)
      $display("FAIL t7_reset: got psel %h en %b rv %b expected 0 0 0", psel, penable, rsp_valid); else passes++;
    preset_n = 1'b1;
    pready[6] = 1'b1;
    tick(); tick();
    checks++; if (psel !== 16'h0 || rsp_valid !== 1'b0)
      $display("FAIL t7_dropped: got psel %h rv %b expected 0 0", psel, rsp_valid); else passes++;
  endtask

  initial begin
    preset_n  = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_strb  = 4'h0; req_prot = 3'd0;
    rsp_ready = 1'b1;
    pready    = 16'hFFFF;
    pslverr   = 16'h0;
    for (int i = 0; i < 16; i++) prdata[i*32 +: 32] = 32'h5A00_0000 + i;

    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_out_of_range();
    test_timeout();
    test_backpressure();
    test_reset_access();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
